// File: rtl/cpu_stack_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_stack_arb                                                 |
// | Purpose  : Arbiter/sequencer for the single-read/single-write stack RAM. |
// |            Shares the RAM read port between decode operand fetch         |
// |            (top-of-stack and Nth entry) and a debug read port, passes    |
// |            writeback pushes straight to the RAM write port, and bypasses |
// |            pushes into captured read data (the RAM is read-old).         |
// | Ports    : clk, rst_b            clock, async active-low reset           |
// |            dec_*_2a, stall_req_2a decode operand fetch handshake         |
// |            kill_4a               pipeline flush (aborts decode fetch)    |
// |            wb_*_5a               writeback push                          |
// |            dbg_*                 debug read handshake                    |
// |            ram_*                 stack RAM read/write ports              |
// |            stat_*_cnt            statistics counters                     |
// | Options  : STACK_ARB_STATS_EN    enables the statistics counters;        |
// |                                  otherwise stat_* outputs are 0.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cpu_stack_arb #(
    parameter int AW         = 11,
    parameter int DW         = 35,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    // decode operand fetch
    input  logic          dec_req_2a,
    input  logic          dec_need1_2a,
    input  logic [AW-1:0] dec_addr0_2a,
    input  logic [AW-1:0] dec_addr1_2a,
    output logic          dec_valid_2a,
    output logic [DW-1:0] dec_data0_2a,
    output logic [DW-1:0] dec_data1_2a,
    output logic          stall_req_2a,
    // pipeline flush
    input  logic          kill_4a,
    // writeback push
    input  logic          wb_push_5a,
    input  logic [AW-1:0] wb_addr_5a,
    input  logic [DW-1:0] wb_data_5a,
    // debug read
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_data,
    // stack RAM
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    // statistics
    output logic [15:0]   stat_stall_cnt,
    output logic [15:0]   stat_force_cnt
);

    localparam int                  c_STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for a request
        S_R0   = 2'd1,   // capturing operand 0
        S_R1   = 2'd2,   // capturing operand 1
        S_DG   = 2'd3    // capturing debug read data
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [c_STARVE_W-1:0] r_starve;
    logic                  w_starved;

    // Issue-cycle bookkeeping: the address whose data returns next cycle and
    // whether a push to that address landed in the same cycle (RAM returns
    // the old value, so the pushed data must be remembered).
    logic [AW-1:0]         r_cap_addr;
    logic                  r_byp_hit;
    logic [DW-1:0]         r_byp_data;

    logic                  r_dec_valid;
    logic [DW-1:0]         r_dec_data0;
    logic [DW-1:0]         r_dec_data1;
    logic                  r_dbg_ack;
    logic [DW-1:0]         r_dbg_data;

    logic                  w_issue;
    logic [AW-1:0]         w_issue_addr;
    logic                  w_dbg_grant;
    logic                  w_cap0;
    logic                  w_cap1;
    logic                  w_capd;
    logic                  w_r1_fwd0;
    logic                  w_dec_valid_nxt;
    logic                  w_dbg_ack_nxt;
    logic [DW-1:0]         w_cap_data;

    // ------------------------------------------------------------------
    // Write port: pushes are never blocked.
    // ------------------------------------------------------------------
    assign ram_we    = wb_push_5a;
    assign ram_waddr = wb_addr_5a;
    assign ram_wdata = wb_data_5a;

    assign w_starved = (r_starve == c_STARVE_MAX);

    // Capture priority: push in the capture cycle, then push seen in the
    // issue cycle, then RAM data (later write wins).
    always_comb begin
        w_cap_data = ram_rdata;
        if (wb_push_5a && (wb_addr_5a == r_cap_addr)) begin
            w_cap_data = wb_data_5a;
        end else if (r_byp_hit) begin
            w_cap_data = r_byp_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_issue         = 1'b0;
        w_issue_addr    = '0;
        w_dbg_grant     = 1'b0;
        w_cap0          = 1'b0;
        w_cap1          = 1'b0;
        w_capd          = 1'b0;
        w_r1_fwd0       = 1'b0;
        w_dec_valid_nxt = 1'b0;
        w_dbg_ack_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!kill_4a) begin
                    // Decode wins ties unless debug has waited long enough.
                    if (dbg_req && (w_starved || !dec_req_2a)) begin
                        w_dbg_grant  = 1'b1;
                        w_issue      = 1'b1;
                        w_issue_addr = dbg_addr;
                        w_state_nxt  = S_DG;
                    end else if (dec_req_2a) begin
                        w_issue      = 1'b1;
                        w_issue_addr = dec_addr0_2a;
                        w_state_nxt  = S_R0;
                    end
                end
            end

            S_R0: begin
                if (kill_4a) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cap0 = 1'b1;
                    if (dec_need1_2a) begin
                        w_issue      = 1'b1;
                        w_issue_addr = dec_addr1_2a;
                        w_state_nxt  = S_R1;
                    end else begin
                        w_dec_valid_nxt = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end
                end
            end

            S_R1: begin
                w_state_nxt = S_IDLE;
                if (!kill_4a) begin
                    w_cap1          = 1'b1;
                    w_dec_valid_nxt = 1'b1;
                    // Operand 0 was captured a cycle ago; keep it coherent
                    // with a push to its address arriving now.
                    w_r1_fwd0       = wb_push_5a && (wb_addr_5a == dec_addr0_2a);
                end
            end

            S_DG: begin
                w_capd        = 1'b1;
                w_dbg_ack_nxt = 1'b1;
                w_state_nxt   = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ram_raddr = w_issue_addr;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_starve    <= '0;
            r_cap_addr  <= '0;
            r_byp_hit   <= 1'b0;
            r_byp_data  <= '0;
            r_dec_valid <= 1'b0;
            r_dec_data0 <= '0;
            r_dec_data1 <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dec_valid <= w_dec_valid_nxt;
            r_dbg_ack   <= w_dbg_ack_nxt;

            if (w_issue) begin
                r_cap_addr <= w_issue_addr;
                r_byp_hit  <= wb_push_5a && (wb_addr_5a == w_issue_addr);
                r_byp_data <= wb_data_5a;
            end

            if (w_cap0) begin
                r_dec_data0 <= w_cap_data;
            end else if (w_r1_fwd0) begin
                r_dec_data0 <= wb_data_5a;
            end

            if (w_cap1) begin
                r_dec_data1 <= w_cap_data;
            end

            if (w_capd) begin
                r_dbg_data <= w_cap_data;
            end

            if (!dbg_req || w_dbg_grant) begin
                r_starve <= '0;
            end else if (!w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign dec_valid_2a = r_dec_valid;
    assign dec_data0_2a = r_dec_data0;
    assign dec_data1_2a = r_dec_data1;
    assign dbg_ack      = r_dbg_ack;
    assign dbg_data     = r_dbg_data;
    assign stall_req_2a = dec_req_2a & ~r_dec_valid;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef STACK_ARB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_force_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_stall_cnt <= '0;
            r_force_cnt <= '0;
        end else begin
            if (stall_req_2a && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_dbg_grant && w_starved && (r_force_cnt != 16'hFFFF)) begin
                r_force_cnt <= r_force_cnt + 16'd1;
            end
        end
    end

    assign stat_stall_cnt = r_stall_cnt;
    assign stat_force_cnt = r_force_cnt;
`else
    assign stat_stall_cnt = '0;
    assign stat_force_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_stack_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu_stack_arb                                              |
// | Purpose  : Self-checking bench for cpu_stack_arb with a read-old RAM     |
// |            model, vector table for decode fetches and scoreboards for   |
// |            decode and debug read results.                               |
// | Options  : STACK_ARB_STATS_EN    also checks the statistics counters.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cpu_stack_arb;

    localparam int AW = 11;
    localparam int DW = 35;

    logic          clk;
    logic          rst_b;
    logic          dec_req_2a;
    logic          dec_need1_2a;
    logic [AW-1:0] dec_addr0_2a;
    logic [AW-1:0] dec_addr1_2a;
    logic          dec_valid_2a;
    logic [DW-1:0] dec_data0_2a;
    logic [DW-1:0] dec_data1_2a;
    logic          stall_req_2a;
    logic          kill_4a;
    logic          wb_push_5a;
    logic [AW-1:0] wb_addr_5a;
    logic [DW-1:0] wb_data_5a;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_ack;
    logic [DW-1:0] dbg_data;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [15:0]   stat_stall_cnt;
    logic [15:0]   stat_force_cnt;

    cpu_stack_arb #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .dec_req_2a     (dec_req_2a),
        .dec_need1_2a   (dec_need1_2a),
        .dec_addr0_2a   (dec_addr0_2a),
        .dec_addr1_2a   (dec_addr1_2a),
        .dec_valid_2a   (dec_valid_2a),
        .dec_data0_2a   (dec_data0_2a),
        .dec_data1_2a   (dec_data1_2a),
        .stall_req_2a   (stall_req_2a),
        .kill_4a        (kill_4a),
        .wb_push_5a     (wb_push_5a),
        .wb_addr_5a     (wb_addr_5a),
        .wb_data_5a     (wb_data_5a),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_ack        (dbg_ack),
        .dbg_data       (dbg_data),
        .ram_raddr      (ram_raddr),
        .ram_rdata      (ram_rdata),
        .ram_we         (ram_we),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .stat_stall_cnt (stat_stall_cnt),
        .stat_force_cnt (stat_force_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-old synchronous RAM: a same-cycle write is not visible to the read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    // Reference contents, updated by the stimulus process only.
    logic [DW-1:0] mdl [0:(1<<AW)-1];

    typedef struct {
        logic [AW-1:0] addr0;
        logic [AW-1:0] addr1;
        logic          need1;
        int            push_cyc;   // cycle index of a push, -1 none
        logic [AW-1:0] push_addr;
        logic [DW-1:0] push_data;
        int            kill_cyc;   // cycle index of kill_4a, -1 none
        int            exp_lat;    // cycles from request to dec_valid_2a
    } vec_t;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] dbg_q [$];
    vec_t          vecs [10];

    int            n_chk;
    int            n_err;
    int            exp_stall;
    logic [DW-1:0] h_d0;
    logic [DW-1:0] h_d1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_push_5a = 1'b1;
        wb_addr_5a = a;
        wb_data_5a = d;
        mdl[a]     = d;
        #1;
        chk("wr_we", ram_we, 1'b1);
        chk("wr_waddr", ram_waddr, a);
        chk("wr_wdata", ram_wdata, d);
        tick();
        wb_push_5a = 1'b0;
    endtask

    task automatic run_dec(input vec_t v);
        exp_t e;
        bit   done;
        int   cyc;
        if (v.push_cyc >= 0) mdl[v.push_addr] = v.push_data;
        if (v.kill_cyc < 0) begin
            e.d0 = mdl[v.addr0];
            e.d1 = v.need1 ? mdl[v.addr1] : h_d1;
            exp_q.push_back(e);
            exp_stall += v.exp_lat;
        end else begin
            exp_stall += v.kill_cyc + 1;
        end
        dec_req_2a   = 1'b1;
        dec_addr0_2a = v.addr0;
        dec_addr1_2a = v.addr1;
        dec_need1_2a = v.need1;
        done = 1'b0;
        cyc  = 0;
        while (!done) begin
            if (v.kill_cyc >= 0 && cyc == v.kill_cyc + 1) begin
                kill_4a    = 1'b0;
                wb_push_5a = 1'b0;
                chk("kill_no_valid", dec_valid_2a, 1'b0);
                chk("kill_hold_d0", dec_data0_2a, h_d0);
                chk("kill_hold_d1", dec_data1_2a, h_d1);
                #1;
                chk("kill_idle_reissue", ram_raddr, v.addr0);
                dec_req_2a = 1'b0;
                done = 1'b1;
            end else if (dec_valid_2a) begin
                wb_push_5a = 1'b0;
                chk("dec_latency", cyc, v.exp_lat);
                chk("dec_stall_at_valid", stall_req_2a, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("dec_unexpected_valid", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_data0", dec_data0_2a, e.d0);
                    chk("dec_data1", dec_data1_2a, e.d1);
                    h_d0 = e.d0;
                    h_d1 = e.d1;
                end
                dec_req_2a = 1'b0;
                done = 1'b1;
            end else if (cyc >= 8) begin
                chk("dec_timeout", 1'b0, 1'b1);
                dec_req_2a = 1'b0;
                done = 1'b1;
            end else begin
                wb_push_5a = (cyc == v.push_cyc);
                wb_addr_5a = v.push_addr;
                wb_data_5a = v.push_data;
                kill_4a    = (cyc == v.kill_cyc);
                #1;
                chk("dec_stall", stall_req_2a, 1'b1);
                if (cyc == 0) chk("dec_issue_raddr", ram_raddr, v.addr0);
                tick();
                cyc++;
            end
        end
        wb_push_5a = 1'b0;
        kill_4a    = 1'b0;
        tick();
    endtask

    task automatic run_dbg(input logic [AW-1:0] a, input bit kill_dg);
        logic [DW-1:0] e;
        bit            done;
        int            cyc;
        dbg_q.push_back(mdl[a]);
        dbg_req  = 1'b1;
        dbg_addr = a;
        done = 1'b0;
        cyc  = 0;
        while (!done) begin
            if (dbg_ack) begin
                kill_4a = 1'b0;
                chk("dbg_latency", cyc, 2);
                e = dbg_q.pop_front();
                chk("dbg_data", dbg_data, e);
                dbg_req = 1'b0;
                done = 1'b1;
            end else if (cyc >= 8) begin
                chk("dbg_timeout", 1'b0, 1'b1);
                dbg_req = 1'b0;
                done = 1'b1;
            end else begin
                kill_4a = kill_dg && (cyc == 1);
                #1;
                if (cyc == 0) chk("dbg_issue_raddr", ram_raddr, a);
                tick();
                cyc++;
            end
        end
        kill_4a = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] e;
        int            n_valid;
        int            ack_cyc;

        n_chk = 0; n_err = 0; exp_stall = 0;
        h_d0 = '0; h_d1 = '0;
        rst_b = 1'b0;
        dec_req_2a = 1'b0; dec_need1_2a = 1'b0; dec_addr0_2a = '0; dec_addr1_2a = '0;
        kill_4a = 1'b0; wb_push_5a = 1'b0; wb_addr_5a = '0; wb_data_5a = '0;
        dbg_req = 1'b0; dbg_addr = '0;

        //        addr0    addr1    n1  pc  paddr    pdata             kc  lat
        vecs[0] = '{11'h010, 11'h000, 1'b0, -1, 11'h000, 35'h0,            -1, 2};
        vecs[1] = '{11'h005, 11'h003, 1'b1, -1, 11'h000, 35'h0,            -1, 3};
        vecs[2] = '{11'h007, 11'h000, 1'b0,  0, 11'h007, 35'h55,           -1, 2};
        vecs[3] = '{11'h008, 11'h000, 1'b0,  1, 11'h008, 35'h55,           -1, 2};
        vecs[4] = '{11'h007, 11'h003, 1'b1,  2, 11'h007, 35'h77,           -1, 3};
        vecs[5] = '{11'h7FF, 11'h000, 1'b1,  1, 11'h000, 35'h4_0000_0004,  -1, 3};
        vecs[6] = '{11'h020, 11'h7FF, 1'b1,  2, 11'h7FF, 35'h5_5555_5555,  -1, 3};
        vecs[7] = '{11'h005, 11'h000, 1'b0,  0, 11'h006, 35'h99,           -1, 2};
        vecs[8] = '{11'h005, 11'h010, 1'b1, -1, 11'h000, 35'h0,             2, 3};
        vecs[9] = '{11'h003, 11'h005, 1'b1, -1, 11'h000, 35'h0,             1, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        chk("rst_dec_valid", dec_valid_2a, 1'b0);
        chk("rst_dec_data0", dec_data0_2a, '0);
        chk("rst_dec_data1", dec_data1_2a, '0);
        chk("rst_dbg_ack", dbg_ack, 1'b0);
        chk("rst_dbg_data", dbg_data, '0);
        chk("rst_stall", stall_req_2a, 1'b0);
        chk("rst_raddr", ram_raddr, '0);
        chk("rst_stat_stall", stat_stall_cnt, 16'h0);
        chk("rst_stat_force", stat_force_cnt, 16'h0);

        wr(11'h010, 35'h1_2345_6789);
        wr(11'h005, 35'hA);
        wr(11'h003, 35'hB);
        wr(11'h007, 35'h1);
        wr(11'h008, 35'h1);
        wr(11'h020, 35'h2_0000_0020);
        wr(11'h7FF, 35'h7_FFFF_FFFF);
        wr(11'h000, 35'h3_1111_2222);
        wr(11'h006, 35'h6);
        tick();

        for (int i = 0; i < 10; i++) begin
            run_dec(vecs[i]);
        end

        run_dbg(11'h020, 1'b0);
        run_dbg(11'h005, 1'b1);

        // Starvation: decode requests back-to-back, debug waits for the
        // forced grant after 8 denied cycles.
        dbg_q.push_back(mdl[11'h020]);
        dec_req_2a   = 1'b1;
        dec_addr0_2a = 11'h010;
        dec_need1_2a = 1'b0;
        dbg_req      = 1'b1;
        dbg_addr     = 11'h020;
        n_valid = 0;
        ack_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (dec_valid_2a) begin
                n_valid++;
                chk("starve_dec_data0", dec_data0_2a, mdl[11'h010]);
            end
            if (dbg_ack) begin
                ack_cyc = c;
                e = dbg_q.pop_front();
                chk("starve_dbg_data", dbg_data, e);
                dbg_req    = 1'b0;
                dec_req_2a = 1'b0;
                break;
            end
            if (c == 0) begin
                #1;
                chk("starve_dec_wins_tie", ram_raddr, 11'h010);
            end
            tick();
        end
        dbg_req    = 1'b0;
        dec_req_2a = 1'b0;
        chk("starve_ack_cycle", ack_cyc, 10);
        chk("starve_dec_valids", n_valid, 4);
        h_d0 = mdl[11'h010];
        exp_stall += 6;
        tick();
        tick();

`ifdef STACK_ARB_STATS_EN
        chk("stat_force_cnt", stat_force_cnt, 16'd1);
        chk("stat_stall_cnt", stat_stall_cnt, exp_stall);
`else
        chk("stat_force_cnt_off", stat_force_cnt, 16'd0);
        chk("stat_stall_cnt_off", stat_stall_cnt, 16'd0);
`endif

        // Reset while in R1.
        dec_req_2a   = 1'b1;
        dec_addr0_2a = 11'h005;
        dec_addr1_2a = 11'h003;
        dec_need1_2a = 1'b1;
        tick();
        tick();
        rst_b      = 1'b0;
        dec_req_2a = 1'b0;
        #1;
        chk("mid_rst_dec_data0", dec_data0_2a, '0);
        chk("mid_rst_dec_data1", dec_data1_2a, '0);
        chk("mid_rst_dec_valid", dec_valid_2a, 1'b0);
        chk("mid_rst_dbg_data", dbg_data, '0);
        chk("mid_rst_stat_stall", stat_stall_cnt, 16'h0);
        chk("mid_rst_raddr", ram_raddr, '0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_no_valid", dec_valid_2a, 1'b0);
            chk("post_rst_no_ack", dbg_ack, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
